// File: rtl/data_memory_pkg.sv
// Shared types and limits for the banked data memory.
// Access sizes, controller states and the read-latency ceiling live here.
package data_memory_pkg;

    localparam int MAX_READ_LATENCY = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic size_legal(input logic [1:0] size);
        return size != 2'd3;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32 loads/stores: byte enables, store-data replication, load extract/extend.
// DATA_MEMORY_MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of silently aligning them.
module mem_lane_align
    import data_memory_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [1:0]  eff_off,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Offsets are forced to natural alignment; the trap build additionally reports the mismatch.
    always_comb begin
        eff_off   = 2'd0;
        byte_en   = 4'b0000;
        wdata_rep = req_wdata;
        misalign  = 1'b0;
        case (req_size)
            SIZE_B: begin
                eff_off   = req_off;
                byte_en   = 4'b0001 << req_off;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                eff_off   = {req_off[1], 1'b0};
                byte_en   = req_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
                misalign  = req_off[0];
`endif
            end
            SIZE_W: begin
                byte_en   = 4'b1111;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
                misalign  = (req_off != 2'd0);
`endif
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

    always_comb begin
        shifted = ld_raw >> {ld_off, 3'b000};
        case (ld_size)
            SIZE_B:  ld_data = {{24{shifted[7] & ~ld_unsigned}}, shifted[7:0]};
            SIZE_H:  ld_data = {{16{shifted[15] & ~ld_unsigned}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/data_memory_banked.sv
// Banked RV32 data memory with valid/ready request/response, configurable read latency and reset clear.
// DATA_MEMORY_MISALIGN_TRAP_EN (see mem_lane_align) turns misaligned half/word accesses into faults.
module data_memory_banked
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1,
    parameter bit INIT_ZERO    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LAT_W = $clog2(MAX_READ_LATENCY + 1);

    state_e           state_reg, state_next;
    logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
    logic [IDX_W-1:0] cnt_reg, idx_reg;
    logic [1:0]       ld_size_reg, ld_off_reg;
    logic             ld_unsigned_reg, write_reg, err_reg;

    logic [IDX_W-1:0] req_idx, wr_idx, rd_idx;
    logic             accept, req_fault, mem_we, mem_re, misalign;
    logic [1:0]       eff_off;
    logic [3:0]       byte_en, mem_be;
    logic [31:0]      wdata_rep, mem_wdata, raw_data, ld_data;

    mem_lane_align u_align (
        .req_size    (req_size),
        .req_off     (req_addr[1:0]),
        .req_wdata   (req_wdata),
        .eff_off     (eff_off),
        .byte_en     (byte_en),
        .wdata_rep   (wdata_rep),
        .misalign    (misalign),
        .ld_size     (ld_size_reg),
        .ld_off      (ld_off_reg),
        .ld_unsigned (ld_unsigned_reg),
        .ld_raw      (raw_data),
        .ld_data     (ld_data)
    );

    assign req_idx   = req_addr[IDX_W+1:2];
    assign req_fault = !size_legal(req_size) || ((req_addr >> (IDX_W + 2)) != 32'd0) || misalign;
    assign accept    = req_valid && req_ready;

    // Single write port shared by the reset clear sweep and accepted stores.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = byte_en;
        wr_idx    = req_idx;
        mem_wdata = wdata_rep;
        if (state_reg == ST_INIT) begin
            mem_we    = !rst;
            mem_be    = 4'b1111;
            wr_idx    = cnt_reg;
            mem_wdata = 32'd0;
        end else if (accept && req_write && !req_fault) begin
            mem_we = 1'b1;
        end
    end

    // Latency 1 samples at acceptance; longer latencies sample on the last WAIT cycle.
    always_comb begin
        rd_idx = (state_reg == ST_IDLE) ? req_idx : idx_reg;
        if (state_reg == ST_IDLE)
            mem_re = accept && (READ_LATENCY <= 1);
        else
            mem_re = (state_reg == ST_WAIT) && (lat_cnt_reg == LAT_W'(1));
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (mem_we && mem_be[gi])
                    lane_mem[wr_idx] <= mem_wdata[8*gi +: 8];
                if (mem_re)
                    lane_rd_reg <= lane_mem[rd_idx];
            end

            assign raw_data[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= INIT_ZERO ? ST_INIT : ST_IDLE;
            lat_cnt_reg     <= '0;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            ld_size_reg     <= 2'd0;
            ld_off_reg      <= 2'd0;
            ld_unsigned_reg <= 1'b0;
            write_reg       <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            if (state_reg == ST_INIT)
                cnt_reg <= cnt_reg + 1'b1;
            if (accept) begin
                idx_reg         <= req_idx;
                ld_size_reg     <= req_size;
                ld_off_reg      <= eff_off;
                ld_unsigned_reg <= req_unsigned;
                write_reg       <= req_write;
                err_reg         <= req_fault;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (&cnt_reg)
                    state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    if (req_write || READ_LATENCY <= 1) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next   = ST_WAIT;
                        lat_cnt_next = LAT_W'(READ_LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (lat_cnt_reg == LAT_W'(1))
                    state_next = ST_RESP;
                else
                    lat_cnt_next = lat_cnt_reg - 1'b1;
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == ST_IDLE) && !rst;
        rsp_valid = (state_reg == ST_RESP);
        rsp_error = rsp_valid && err_reg;
        rsp_rdata = (rsp_valid && !err_reg && !write_reg) ? ld_data : 32'd0;
    end

endmodule

// File: tb/tb_data_memory_banked.sv
// Directed bench for data_memory_banked (64 words, read latency 3, reset clear enabled).
// Honours DATA_MEMORY_MISALIGN_TRAP_EN when choosing the expected misaligned-store outcome.
module tb_data_memory_banked;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_banked #(
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (LAT),
        .INIT_ZERO    (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One complete request/response with rsp_ready held high; lat counts edges from acceptance to response.
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            failures++;
            $error("FAIL req_ready_timeout observed=0 expected=1");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_error;
        $display("xact wr=%0b addr=%h size=%0d uns=%0b wdata=%h -> rdata=%h err=%0b lat=%0d",
                 wr, addr, sz, uns, wd, rd, er, lat);
        @(posedge clk); #1;
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, addr, 2'd2, 1'b0, wd, rd, er, lat);
        chk("store_err", {31'd0, er}, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] exp);
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, addr, sz, uns, 32'd0, rd, er, lat);
        chk(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        logic        bad;

        // Reset and clear sweep
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        rst = 1'b0;
        n = 1;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("init_busy_cycles", n, DEPTH);
        rd_chk("init_zero_load", 32'h3C, 2'd2, 1'b0, 32'd0);

        // Word store then latency-3 load
        xact(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, lat);
        chk("sw_lat", lat, 1);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        xact(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd, er, lat);
        chk("lw_lat", lat, LAT);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'd0, er}, 32'd0);

        // Lane extraction and extension
        wr_word(32'h20, 32'h80FF7F01);
        rd_chk("lb_23", 32'h23, 2'd0, 1'b0, 32'hFFFFFF80);
        rd_chk("lbu_23", 32'h23, 2'd0, 1'b1, 32'h00000080);
        rd_chk("lh_22", 32'h22, 2'd1, 1'b0, 32'hFFFF80FF);
        rd_chk("lhu_20", 32'h20, 2'd1, 1'b1, 32'h00007F01);
        rd_chk("lb_21", 32'h21, 2'd0, 1'b0, 32'h0000007F);
        rd_chk("lw_unsigned_ignored", 32'h20, 2'd2, 1'b1, 32'h80FF7F01);

        // Partial stores
        wr_word(32'h20, 32'h11223344);
        xact(1'b1, 32'h21, 2'd0, 1'b0, 32'h123456AA, rd, er, lat);
        rd_chk("sb_21_word", 32'h20, 2'd2, 1'b0, 32'h1122AA44);
        xact(1'b1, 32'h22, 2'd1, 1'b0, 32'h9876BEEF, rd, er, lat);
        rd_chk("sh_22_word", 32'h20, 2'd2, 1'b0, 32'hBEEFAA44);

        // Backpressure: response held, second request waits for the handshake
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h20;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", lat, LAT);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_after_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_after_hs_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_second_accepted", {31'd0, req_ready}, 32'd0);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_second_lat", lat, LAT);
        chk("bp_second_rdata", rsp_rdata, 32'hBEEFAA44);
        @(posedge clk); #1;

        // Faults
        xact(1'b1, 32'h20, 2'd3, 1'b0, 32'h00000000, rd, er, lat);
        chk("size3_store_err", {31'd0, er}, 32'd1);
        rd_chk("size3_mem_unchanged", 32'h20, 2'd2, 1'b0, 32'hBEEFAA44);
        xact(1'b0, 32'h20, 2'd3, 1'b0, 32'd0, rd, er, lat);
        chk("size3_load_err", {31'd0, er}, 32'd1);
        chk("size3_load_rdata", rd, 32'd0);
        xact(1'b0, DEPTH * 4, 2'd2, 1'b0, 32'd0, rd, er, lat);
        chk("oob_load_err", {31'd0, er}, 32'd1);
        chk("oob_load_rdata", rd, 32'd0);
        wr_word(32'h0, 32'h5A5A5A5A);
        xact(1'b1, DEPTH * 4, 2'd2, 1'b0, 32'hFFFFFFFF, rd, er, lat);
        chk("oob_store_err", {31'd0, er}, 32'd1);
        rd_chk("oob_store_no_alias", 32'h0, 2'd2, 1'b0, 32'h5A5A5A5A);

        // Misaligned word store
        wr_word(32'h30, 32'h01020304);
        xact(1'b1, 32'h31, 2'd2, 1'b0, 32'hCAFEF00D, rd, er, lat);
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        chk("misalign_sw_err", {31'd0, er}, 32'd1);
        rd_chk("misalign_sw_word", 32'h30, 2'd2, 1'b0, 32'h01020304);
`else
        chk("misalign_sw_err", {31'd0, er}, 32'd0);
        rd_chk("misalign_sw_word", 32'h30, 2'd2, 1'b0, 32'hCAFEF00D);
`endif

        // Reset during WAIT drops the load and re-clears the array
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("midwait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = rsp_valid;
        n = 1;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            bad = bad | rsp_valid;
            n++;
            @(negedge clk);
        end
        chk("midwait_no_response", {31'd0, bad}, 32'd0);
        chk("reinit_busy_cycles", n, DEPTH);
        rd_chk("reinit_word_10", 32'h10, 2'd2, 1'b0, 32'd0);
        rd_chk("reinit_byte_23", 32'h23, 2'd0, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
